// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - parallel-to-serial operand feeder and sum collector for the bit-serial adder
//
// Accepts two WIDTH-bit operands over in_valid/in_ready. It shifts them LSB first
// onto X/Y and then adds one 0/0 pad bit, which flushes the adder carry. It
// gathers the registered Z stream into a WIDTH+1-bit sum, offered on
// out_valid/out_ready.
//
// Ports:
//   CLK        clock, rising edge
//   Reset      asynchronous active-low reset (shared with the serial adder)
//   in_valid   operands a/b valid
//   in_ready   controller idle and able to take operands
//   a, b       WIDTH-bit operands
//   X, Y       registered serial operand bits to the adder, LSB first
//   Z          registered serial sum bit from the adder
//   out_valid  sum valid
//   out_ready  consumer takes the sum
//   sum        a+b, sum[WIDTH] is the carry-out
//   busy       operation in flight or result waiting
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             X,
    output logic             Y,
    input  logic             Z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [CW-1:0]  cnt;
    logic [WIDTH:0] acc;
    logic           accept;
    logic           capture;
    logic           last;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                // Z lags the presented bit by two edges, so nothing valid arrives
                // on the first busy edge (cnt==0).
                capture = (cnt != '0);
                last    = (cnt == CNT_LAST);
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            sa  <= '0;
            sb  <= '0;
            cnt <= '0;
            acc <= '0;
            sum <= '0;
            X   <= 1'b0;
            Y   <= 1'b0;
        end else begin
            if (accept) begin
                // Bit 0 goes straight to X/Y and the rest waits in sa/sb. That
                // way X/Y are true flops and bit k is on the wire after the k-th edge.
                X   <= a[0];
                Y   <= b[0];
                sa  <= a >> 1;
                sb  <= b >> 1;
                cnt <= '0;
            end else if (state == BUSY) begin
                // Zeros shifted in supply the pad bit and keep X/Y low to the end.
                X   <= last ? 1'b0 : sa[0];
                Y   <= last ? 1'b0 : sb[0];
                sa  <= sa >> 1;
                sb  <= sb >> 1;
                cnt <= last ? '0 : cnt + CW'(1);
            end else begin
                // Idle/done: hold the adder inputs low so its carry stays cleared.
                X <= 1'b0;
                Y <= 1'b0;
            end

            if (capture) begin
                acc <= {Z, acc[WIDTH:1]};
            end
            if (last) begin
                sum <= {Z, acc[WIDTH:1]};
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl with a behavioural serial adder
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic         Reset;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [W-1:0] a, b;
    logic         X, Y, Z;
    logic [W:0]   sum;

    logic         in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic         a1, b1, X1, Y1, Z1;
    logic [1:0]   sum1;

    logic         c8, c1;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .CLK(CLK), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .X(X), .Y(Y), .Z(Z), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .busy(busy)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .CLK(CLK), .Reset(Reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .X(X1), .Y(Y1), .Z(Z1), .out_valid(out_valid1),
        .out_ready(out_ready1), .sum(sum1), .busy(busy1)
    );

    // Serial adders: registered sum bit and carry, cleared by the shared reset.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            Z  <= 1'b0;
            c8 <= 1'b0;
            Z1 <= 1'b0;
            c1 <= 1'b0;
        end else begin
            Z  <= X ^ Y ^ c8;
            c8 <= (X & Y) | (X & c8) | (Y & c8);
            Z1 <= X1 ^ Y1 ^ c1;
            c1 <= (X1 & Y1) | (X1 & c1) | (Y1 & c1);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One full transaction; assumes the caller is just after a rising edge.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input int hold, output logic [W:0] got);
        logic [W:0] held;
        logic [W:0] expect_sum;
        int lat;
        expect_sum = {1'b0, ta} + {1'b0, tb_v};
        chk("op_in_ready_idle", in_ready, 1);
        a = ta;
        b = tb_v;
        in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge CLK); #1;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge CLK); #1;
            lat++;
        end
        chk("op_latency", lat, W + 2);
        chk("op_sum", sum, expect_sum);
        got = sum;
        held = sum;
        for (int i = 0; i < hold; i++) begin
            chk("hold_out_valid", out_valid, 1);
            chk("hold_sum", sum, held);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_xy", {X, Y}, 0);
            @(posedge CLK); #1;
        end
        out_ready = 1'b1;
        @(posedge CLK); #1;
        chk("op_out_valid_drop", out_valid, 0);
        chk("op_in_ready_back", in_ready, 1);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   s;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [W:0]   got;
        logic [W-1:0] ta, tbv;
        int lat;

        tbl[0] = '{8'h05, 8'h03, 9'h008};
        tbl[1] = '{8'hFF, 8'h01, 9'h100};
        tbl[2] = '{8'h01, 8'h00, 9'h001};
        tbl[3] = '{8'hFF, 8'hFF, 9'h1FE};
        tbl[4] = '{8'h00, 8'h00, 9'h000};
        tbl[5] = '{8'h80, 8'h80, 9'h100};
        tbl[6] = '{8'hAA, 8'h55, 9'h0FF};
        tbl[7] = '{8'h7F, 8'h01, 9'h080};

        Reset = 1'b0;
        in_valid = 0; out_ready = 0; a = '0; b = '0;
        in_valid1 = 0; out_ready1 = 0; a1 = 0; b1 = 0;
        #12;
        chk("rst_x", X, 0);
        chk("rst_y", Y, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_busy", busy, 0);
        Reset = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        @(posedge CLK); #1;

        // Serial bit order, pad bit and latency for 5+3.
        ta = 8'h05; tbv = 8'h03;
        a = ta; b = tbv; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        for (int k = 0; k <= W; k++) begin
            chk("seq_x", X, (k < W) ? ta[k] : 1'b0);
            chk("seq_y", Y, (k < W) ? tbv[k] : 1'b0);
            chk("seq_busy", busy, 1);
            @(posedge CLK); #1;
        end
        chk("seq_not_yet_valid", out_valid, 0);
        @(posedge CLK); #1;
        chk("seq_valid_at_10", out_valid, 1);
        chk("seq_sum", sum, 9'h008);
        @(posedge CLK); #1;
        chk("seq_handshake", out_valid, 0);

        // Table vectors back to back (FF+01 then 01+00 proves the carry flush).
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].a, tbl[i].b, 0, got);
            chk("tbl_sum", got, tbl[i].s);
        end

        // Consumer stalls for five cycles.
        run_op(8'hFF, 8'hFF, 5, got);
        chk("stall_sum", got, 9'h1FE);

        // in_valid toggling with other operands while busy must be ignored.
        a = 8'h12; b = 8'h34; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            in_valid = ~in_valid;
            a = 8'hAA;
            b = 8'h55;
            chk("toggle_in_ready", in_ready, 0);
            @(posedge CLK); #1;
            lat++;
        end
        in_valid = 1'b0;
        chk("toggle_latency", lat, W + 2);
        chk("toggle_sum", sum, 9'h046);
        @(posedge CLK); #1;
        chk("toggle_done", out_valid, 0);
        chk("toggle_in_ready_back", in_ready, 1);

        // Reset in the middle of an operation.
        a = 8'hF0; b = 8'h0F; in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge CLK);
        #3;
        Reset = 1'b0;
        #1;
        chk("midrst_x", X, 0);
        chk("midrst_y", Y, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_busy", busy, 0);
        #2;
        Reset = 1'b1;
        @(posedge CLK); #1;
        chk("midrst_no_pulse", out_valid, 0);
        run_op(8'h02, 8'h02, 0, got);
        chk("midrst_new_sum", got, 9'h004);

        // Single-bit instance, all operand pairs.
        for (int i = 0; i < 4; i++) begin
            logic va, vb;
            va = (i >= 2);
            vb = (i % 2 == 1);
            a1 = va; b1 = vb; in_valid1 = 1'b1; out_ready1 = 1'b1;
            @(posedge CLK); #1;
            in_valid1 = 1'b0;
            lat = 0;
            while (!out_valid1 && lat < 20) begin
                @(posedge CLK); #1;
                lat++;
            end
            chk("w1_latency", lat, 3);
            chk("w1_sum", sum1, {1'b0, va} + {1'b0, vb});
            @(posedge CLK); #1;
            chk("w1_done", out_valid1, 0);
        end

        // Random sweep against plain addition.
        for (int n = 0; n < 200; n++) begin
            ta = W'($urandom);
            tbv = W'($urandom);
            run_op(ta, tbv, $urandom_range(0, 2), got);
            chk("rand_sum", got, {1'b0, ta} + {1'b0, tbv});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
